// File: rtl/frame_fetcher_if.sv
// Bundle of the frame fetcher's request, read-back, pixel-stream and status signals.
// The master modport is the fetcher's view; slave is the surrounding system's view.
interface frame_fetcher_if;
    logic        start;
    logic [16:0] fetch_addr;
    logic [31:0] fetch_wrdata;
    logic [3:0]  fetch_op;
    logic        fetch_rts;
    logic        fetch_rtr;
    logic [31:0] bcast_data;
    logic        bcast_xfc;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;
    logic        stray_err;

    modport master (
        input  start, fetch_rtr, bcast_data, bcast_xfc, pix_ready,
        output fetch_addr, fetch_wrdata, fetch_op, fetch_rts,
        output pix_data, pix_valid, busy, frame_done, stray_err
    );

    modport slave (
        output start, fetch_rtr, bcast_data, bcast_xfc, pix_ready,
        input  fetch_addr, fetch_wrdata, fetch_op, fetch_rts,
        input  pix_data, pix_valid, busy, frame_done, stray_err
    );
endinterface

// File: rtl/frame_fetcher.sv
// Streams NUM_WORDS words from BASE_ADDR through an arbitrated read port into a
// small FIFO, issuing a request only when the FIFO is guaranteed room for its data.
module frame_fetcher #(
    parameter logic [16:0] BASE_ADDR  = 17'h00000,
    parameter int          NUM_WORDS  = 19200,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    frame_fetcher_if.master  bus
);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = PW + 1;
    localparam logic [17:0] LAST_ISSUE = 18'(NUM_WORDS - 1);
    localparam logic [CW:0] DEPTH_W    = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [16:0]     addr_q, addr_d;
    logic [17:0]     issued_q, issued_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   fifo_count_q, fifo_count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            stray_q, stray_d;

    logic [31:0]     fifo_mem [FIFO_DEPTH];

    logic            rts;
    logic            busy;
    logic            frame_done;
    logic            xfc;
    logic            push;
    logic            pop;
    logic            pix_valid;
    logic            stray_hit;
    logic [CW:0]     in_flight;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= BASE_ADDR;
            issued_q      <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            stray_q       <= stray_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (xfc && issued_q == LAST_ISSUE) state_d = DRAIN;
            DRAIN:   if (outstanding_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Words in flight plus words buffered can only shrink while a request
    // waits, so the credit condition cannot fall away before the grant arrives.
    always_comb begin
        in_flight  = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
        rts        = (state_q == FETCH) && (issued_q <= LAST_ISSUE) && (in_flight < DEPTH_W);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
    end

    assign pix_valid = (fifo_count_q != '0);
    assign xfc       = rts && bus.fetch_rtr;
    assign push      = bus.bcast_xfc && (outstanding_q != '0);
    assign stray_hit = bus.bcast_xfc && (outstanding_q == '0);
    assign pop       = pix_valid && bus.pix_ready;

    // Request address, counters and FIFO pointers
    always_comb begin
        addr_d        = addr_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        stray_d       = stray_q | stray_hit;

        if (state_q == IDLE && bus.start) begin
            addr_d   = BASE_ADDR;
            issued_d = '0;
        end else if (xfc) begin
            addr_d   = addr_q + 17'd1;
            issued_d = issued_q + 18'd1;
        end

        case ({xfc, push})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Storage is left unreset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.bcast_data;
    end

    assign bus.fetch_addr   = addr_q;
    assign bus.fetch_wrdata = 32'h0;
    assign bus.fetch_op     = 4'b0000;
    assign bus.fetch_rts    = rts;
    assign bus.pix_valid    = pix_valid;
    assign bus.pix_data     = pix_valid ? fifo_mem[rd_ptr_q] : 32'h0;
    assign bus.busy         = busy;
    assign bus.frame_done   = frame_done;
    assign bus.stray_err    = stray_q;
endmodule

// File: tb/tb_frame_fetcher.sv
// Randomized scoreboard bench: a memory/arbiter responder, a negedge monitor with a
// word-count reference model, and a driver running whole-frame scenarios.
module tb_frame_fetcher;
    localparam logic [16:0] BASE  = 17'h1FFFE;
    localparam int          NW    = 10;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    frame_fetcher_if bus();

    frame_fetcher #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rb_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          frame_xfc = 0;
    int          model_out = 0;
    int          model_fifo = 0;
    bit          model_stray = 1'b0;
    int          done_cnt = 0;
    int          rtr_pct = 100;
    int          grant_limit = 1000000;
    int          lat_min = 3;
    int          lat_max = 3;
    bit          stray_req = 1'b0;
    bit          prev_wait = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [31:0] salt = 32'h0;
    logic [31:0] exp_q [$];
    rb_t         rb_q [$];

    function automatic logic [31:0] mem_word(logic [16:0] a, logic [31:0] s);
        return s ^ (32'(a) * 32'h9E3779B1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory + arbiter: random grants, in-order read-back after a random latency
    initial begin
        rb_t r;
        bus.fetch_rtr  = 1'b0;
        bus.bcast_xfc  = 1'b0;
        bus.bcast_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.fetch_rtr = (int'($urandom_range(99)) < rtr_pct) && (frame_xfc < grant_limit);
            if (rb_q.size() != 0 && rb_q[0].due <= cyc) begin
                r = rb_q.pop_front();
                bus.bcast_xfc  = 1'b1;
                bus.bcast_data = r.data;
            end else if (stray_req) begin
                stray_req      = 1'b0;
                bus.bcast_xfc  = 1'b1;
                bus.bcast_data = $urandom;
            end else begin
                bus.bcast_xfc  = 1'b0;
                bus.bcast_data = 32'h0;
            end
        end
    end

    // Monitor: checks state left by the last edge, then books the events of the next edge
    initial begin
        bit xfc, push, pop;
        int due;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_out   = 0;
                model_fifo  = 0;
                model_stray = 1'b0;
                prev_wait   = 1'b0;
                exp_q.delete();
            end else begin
                chk("pix_valid", 32'(bus.pix_valid), 32'(model_fifo != 0));
                chk("stray_err", 32'(bus.stray_err), 32'(model_stray));
                if (bus.frame_done) begin
                    done_cnt++;
                    chk("done_when_complete", 32'(frame_xfc == NW && model_out == 0), 32'd1);
                end
                if (prev_wait) begin
                    chk("rts_hold", 32'(bus.fetch_rts), 32'd1);
                    chk("addr_hold", 32'(bus.fetch_addr), 32'(prev_addr));
                end
                if (bus.fetch_rts)
                    chk("credit", 32'((model_out + model_fifo) < DEPTH), 32'd1);

                xfc  = bus.fetch_rts && bus.fetch_rtr;
                pop  = bus.pix_valid && bus.pix_ready;
                push = bus.bcast_xfc && (model_out > 0);
                if (bus.bcast_xfc && model_out == 0) model_stray = 1'b1;

                if (xfc) begin
                    chk("fetch_addr", 32'(bus.fetch_addr), 32'(17'(BASE + 17'(frame_xfc))));
                    chk("issue_limit", 32'(frame_xfc < NW), 32'd1);
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due < last_due) due = last_due;
                    last_due = due;
                    rb_q.push_back('{due: due, data: mem_word(bus.fetch_addr, salt)});
                    frame_xfc++;
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pix_unexpected: got %h expected no word (cycle %0d)",
                                 bus.pix_data, cyc);
                    end else begin
                        chk("pix_data", bus.pix_data, exp_q.pop_front());
                    end
                end
                model_out  = model_out + int'(xfc) - int'(push);
                model_fifo = model_fifo + int'(push) - int'(pop);
                prev_wait  = bus.fetch_rts && !bus.fetch_rtr;
                prev_addr  = bus.fetch_addr;
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"},       32'(bus.busy), 32'd0);
        chk({tag, "_rts"},        32'(bus.fetch_rts), 32'd0);
        chk({tag, "_addr"},       32'(bus.fetch_addr), 32'(BASE));
        chk({tag, "_pix_valid"},  32'(bus.pix_valid), 32'd0);
        chk({tag, "_pix_data"},   bus.pix_data, 32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_stray_err"},  32'(bus.stray_err), 32'd0);
    endtask

    // rmode 0: always ready; 1: random ready; 2: stalled 40 cycles, then ready
    task automatic run_frame(int pct, int rmode, bit extra_start);
        int d0;
        int n;
        salt = $urandom;
        for (int k = 0; k < NW; k++) exp_q.push_back(mem_word(17'(BASE + 17'(k)), salt));
        rtr_pct       = pct;
        frame_xfc     = 0;
        d0            = done_cnt;
        bus.pix_ready = (rmode != 2);
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            n++;
            if (rmode == 1) bus.pix_ready = 1'($urandom_range(1));
            else if (rmode == 2) bus.pix_ready = (n >= 40);
            bus.start = extra_start && (n == 3);
            if (rmode == 2 && n == 40) begin
                chk("credit_xfc_count", 32'(frame_xfc), 32'(DEPTH));
                chk("credit_rts_low", 32'(bus.fetch_rts), 32'd0);
            end
            step();
        end
        bus.start = 1'b0;
        chk("frame_done_seen", 32'(done_cnt - d0), 32'd1);
        step();
        step();
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("single_done_pulse", 32'(done_cnt - d0), 32'd1);
        bus.pix_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            step();
        end
        step();
        chk("all_words_delivered", 32'(exp_q.size()), 32'd0);
        chk("fifo_empty_end", 32'(bus.pix_valid), 32'd0);
        $display("frame done: pct=%0d rmode=%0d extra_start=%0d issued=%0d", pct, rmode,
                 extra_start, frame_xfc);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        run_frame(100, 0, 1'b0);
        run_frame(100, 2, 1'b0);
        lat_min = 1;
        lat_max = 6;
        run_frame(30, 1, 1'b0);
        run_frame(30, 1, 1'b0);
        run_frame(30, 0, 1'b0);
        run_frame(50, 1, 1'b1);

        // Read-back with nothing outstanding while idle
        stray_req = 1'b1;
        repeat (3) step();
        chk("stray_idle", 32'(bus.stray_err), 32'd1);
        chk("stray_idle_fifo_empty", 32'(bus.pix_valid), 32'd0);
        $display("stray read-back while idle issued");

        // Abandon a frame with two reads in flight
        lat_min     = 8;
        lat_max     = 8;
        grant_limit = 2;
        salt        = $urandom;
        for (int k = 0; k < NW; k++) exp_q.push_back(mem_word(17'(BASE + 17'(k)), salt));
        rtr_pct       = 100;
        frame_xfc     = 0;
        bus.pix_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (frame_xfc < 2 && n < 50) begin
            n++;
            step();
        end
        chk("two_issued_before_reset", 32'(frame_xfc), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst         = 1'b0;
        grant_limit = 1000000;
        n = 0;
        while (!bus.stray_err && n < 20) begin
            n++;
            step();
        end
        chk("stray_after_reset", 32'(bus.stray_err), 32'd1);
        chk("no_data_after_reset", 32'(bus.pix_valid), 32'd0);
        $display("mid-frame reset applied, late read-backs seen");
        lat_min = 1;
        lat_max = 4;
        run_frame(60, 1, 1'b0);
        chk("stray_sticky", 32'(bus.stray_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/frame_fetcher.md
FRAME_FETCHER -- requirements
Module: frame_fetcher

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 17'h00000: word address of the first frame word.
REQ-002 SHALL have parameter NUM_WORDS, default 19200: words per frame, range 1..131072.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: read-back buffer depth, power of two, 2..64.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a frame fetch.
REQ-007 SHALL have port fetch_addr, output, 17 bits: request word address to the arbiter.
REQ-008 SHALL have port fetch_wrdata, output, 32 bits: tied to 0.
REQ-009 SHALL have port fetch_op, output, 4 bits: tied to 4'b0000 (read).
REQ-010 SHALL have port fetch_rts, output, 1 bit: request pending.
REQ-011 SHALL have port fetch_rtr, input, 1 bit: arbiter grant.
REQ-012 SHALL have port bcast_data, input, 32 bits: shared read-back data.
REQ-013 SHALL have port bcast_xfc, input, 1 bit: this client's read-back strobe, which the top level wires to its bit of the arbiter vector.
REQ-014 SHALL have port pix_data, output, 32 bits: FIFO head word.
REQ-015 SHALL have port pix_valid, output, 1 bit: FIFO not empty.
REQ-016 SHALL have port pix_ready, input, 1 bit: consumer accepts.
REQ-017 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-019 SHALL have port stray_err, output, 1 bit: sticky error flag.

Function
REQ-020 SHALL treat a request as transferred (xfc) on a rising edge where fetch_rts and fetch_rtr are both 1.
REQ-021 SHALL treat a FIFO pop as occurring on a rising edge where pix_valid and pix_ready are both 1.
REQ-022 SHALL implement four states: IDLE, FETCH, DRAIN, DONE.
REQ-023 IDLE: on start=1, go to FETCH, set fetch_addr=BASE_ADDR, set issued=0.
REQ-024 SHALL ignore start in every state other than IDLE.
REQ-025 FETCH: assert fetch_rts iff issued<NUM_WORDS and outstanding+fifo_count<FIFO_DEPTH (credit check).
REQ-026 On each xfc, SHALL increment fetch_addr mod 2^17, increment issued, and increment outstanding.
REQ-027 SHALL hold fetch_rts and fetch_addr stable until xfc; once raised, fetch_rts never drops before xfc.
REQ-028 SHALL go from FETCH to DRAIN on the xfc that makes issued==NUM_WORDS.
REQ-029 DRAIN: fetch_rts=0; go to DONE when outstanding==0.
REQ-030 DONE: frame_done=1 for exactly one cycle, then go to IDLE. The FIFO may still hold data.
REQ-031 On bcast_xfc=1 with outstanding>0, SHALL write bcast_data to the FIFO tail and decrement outstanding, with no assumption of fixed read-back latency.
REQ-032 On bcast_xfc=1 with outstanding==0, SHALL drop the data, leave all counters unchanged, and set stray_err; it stays set until rst.
REQ-033 A simultaneous xfc and bcast_xfc SHALL leave outstanding unchanged.
REQ-034 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; a pop from an empty FIFO SHALL never occur.
REQ-035 FIFO first-word latency: bcast_xfc at edge N gives pix_valid=1 with that word after edge N.
REQ-036 Counter widths: issued 18 bits; outstanding and fifo_count each $clog2(FIFO_DEPTH)+1 bits; none may overflow under the REQ-025 credit rule.

Reset
REQ-037 On rst=1, asynchronously set: state=IDLE, fetch_rts=0, fetch_addr=BASE_ADDR, issued=0, outstanding=0, FIFO empty, pix_valid=0, pix_data=0, busy=0, frame_done=0, stray_err=0.
REQ-038 Reset in mid-frame SHALL abandon the frame; read-backs after reset fall under REQ-032.

Verification
REQ-039 NUM_WORDS=4, fetch_rtr=1, 3-cycle read-back model, pix_ready=1, start pulse -> addresses 0,1,2,3 issued on consecutive cycles; pix_data sequence equals memory[0..3]; one frame_done pulse; busy low afterwards.
REQ-040 FIFO_DEPTH=4, NUM_WORDS=10, pix_ready=0 -> fetch_rts drops after exactly 4 xfc; after raising pix_ready, all 10 words arrive in order with no loss.
REQ-041 fetch_rtr random at 30% -> fetch_addr and fetch_rts stay stable while waiting; transfers occur only on rts&rtr edges; data order is preserved.
REQ-042 BASE_ADDR=17'h1FFFE, NUM_WORDS=4 -> addresses 1FFFE, 1FFFF, 00000, 00001.
REQ-043 bcast_xfc pulse while IDLE -> stray_err=1, FIFO stays empty; start pulse while busy -> no effect.
REQ-044 rst asserted with 2 reads outstanding -> all outputs take reset values immediately; a later read-back sets stray_err; a new start fetches a full frame correctly.
